// File: rtl/barrett_seq_ctrl.sv
// Sequencer for the digit-serial Barrett modular multiplier: operand latch, digit streaming,
// result capture. Optional final conditional subtraction under BARRETT_SEQ_FINAL_REDUCE_EN.
module barrett_seq_ctrl #(
  parameter int unsigned n = 8,
  parameter int unsigned m = 4
) (
  input  logic           CLK,
  input  logic           RST,
  input  logic           START,
  input  logic [n-1:0]   A,
  input  logic [n-1:0]   B,
  input  logic [n-1:0]   M,
  input  logic [m+4:0]   MU,
  input  logic           RES_READY,
  input  logic [n:0]     Z_OUT,
  output logic           DP_RST,
  output logic [n-1:0]   DP_X,
  output logic [n-1:0]   DP_M,
  output logic [m+4:0]   DP_MU,
  output logic [m-1:0]   DP_Y_I,
  output logic           DP_CARRY_ADD,
  output logic           DP_CARRY_SUB,
  output logic           BUSY,
  output logic           RES_VALID,
  output logic [n:0]     RESULT
);

  localparam int unsigned D  = n / m;
  localparam int unsigned CW = (D > 1) ? $clog2(D) : 1;

  if (n % m != 0) begin : g_bad_width
    $error("barrett_seq_ctrl: n must be a multiple of m");
  end

  typedef enum logic [2:0] {StIdle, StClr, StZero, StDig, StCap, StDone} state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [n-1:0]    b_q;
  logic            dp_rst_d;
  logic [m-1:0]    y_d;
  logic            valid_d;
  logic [n:0]      result_d;
  logic [n:0]      cap_val;
  logic            latch;

`ifdef BARRETT_SEQ_FINAL_REDUCE_EN
  always_comb begin
    cap_val = Z_OUT;
    if (Z_OUT >= {1'b0, DP_M}) cap_val = Z_OUT - {1'b0, DP_M};
  end
`else
  assign cap_val = Z_OUT;
`endif

  assign DP_CARRY_ADD = 1'b0;
  assign DP_CARRY_SUB = 1'b1;
  assign BUSY         = (state_q != StIdle);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    dp_rst_d = 1'b1;
    y_d      = '0;
    valid_d  = RES_VALID;
    result_d = RESULT;
    latch    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (START) begin
          latch    = 1'b1;
          dp_rst_d = 1'b0;
          state_d  = StClr;
        end
      end
      StClr: state_d = StZero;
      StZero: begin
        // Counter indexes the digit currently presented on DP_Y_I, MSB first.
        cnt_d   = CW'(D - 1);
        y_d     = b_q[32'(cnt_d) * m +: m];
        state_d = StDig;
      end
      StDig: begin
        if (cnt_q == '0) begin
          state_d = StCap;
        end else begin
          cnt_d = cnt_q - 1'b1;
          y_d   = b_q[32'(cnt_d) * m +: m];
        end
      end
      StCap: begin
        result_d = cap_val;
        valid_d  = 1'b1;
        state_d  = StDone;
      end
      StDone: begin
        if (RES_READY) begin
          valid_d = 1'b0;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      b_q       <= '0;
      DP_X      <= '0;
      DP_M      <= '0;
      DP_MU     <= '0;
      DP_RST    <= 1'b0;
      DP_Y_I    <= '0;
      RES_VALID <= 1'b0;
      RESULT    <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      DP_RST    <= dp_rst_d;
      DP_Y_I    <= y_d;
      RES_VALID <= valid_d;
      RESULT    <= result_d;
      if (latch) begin
        DP_X  <= A;
        b_q   <= B;
        DP_M  <= M;
        DP_MU <= MU;
      end
    end
  end

endmodule

// File: tb/tb_barrett_seq_ctrl.sv
// Scoreboard bench for barrett_seq_ctrl with a behavioural digit-serial modular datapath.
module tb_barrett_seq_ctrl;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic        START = 1'b0;
  logic [7:0]  A = '0, B = '0, M = '0;
  logic [8:0]  MU = '0;
  logic        RES_READY = 1'b1;
  logic [8:0]  Z_OUT;
  logic        DP_RST;
  logic [7:0]  DP_X, DP_M;
  logic [8:0]  DP_MU;
  logic [3:0]  DP_Y_I;
  logic        DP_CARRY_ADD, DP_CARRY_SUB, BUSY, RES_VALID;
  logic [8:0]  RESULT;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  longint sb[$];

  barrett_seq_ctrl #(.n(8), .m(4)) dut (
    .CLK(CLK), .RST(RST), .START(START), .A(A), .B(B), .M(M), .MU(MU),
    .RES_READY(RES_READY), .Z_OUT(Z_OUT), .DP_RST(DP_RST), .DP_X(DP_X), .DP_M(DP_M),
    .DP_MU(DP_MU), .DP_Y_I(DP_Y_I), .DP_CARRY_ADD(DP_CARRY_ADD),
    .DP_CARRY_SUB(DP_CARRY_SUB), .BUSY(BUSY), .RES_VALID(RES_VALID), .RESULT(RESULT)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  // Datapath model: Z = (Z*2^m + X*y) mod M each edge, cleared while DP_RST is low.
  longint z;
  logic   zforce = 1'b0;
  always @(posedge CLK or negedge RST) begin
    if (!RST) z <= 0;
    else if (!DP_RST) z <= 0;
    else if (DP_M != 0) z <= (z * 16 + longint'(DP_X) * longint'(DP_Y_I)) % longint'(DP_M);
  end
  assign Z_OUT = zforce ? 9'(DP_M + 9'd3) : 9'(z);

  task automatic check(input string name, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: latency on RES_VALID rise, scoreboard pop on each handshake.
  logic busy_prev = 1'b0, valid_prev = 1'b0;
  int   acc_cyc = 0;
  always @(negedge CLK) begin
    if (RST) begin
      if (BUSY && !busy_prev) acc_cyc = cyc;
      if (RES_VALID && !valid_prev) check("latency", cyc - acc_cyc + 1, 6);
      if (RES_VALID && RES_READY) begin
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_result: got %0d with empty scoreboard", RESULT);
        end else begin
          check("result", RESULT, sb.pop_front());
        end
      end
    end
    busy_prev  = BUSY;
    valid_prev = RES_VALID;
  end

  task automatic wait_idle();
    int n = 0;
    while (BUSY && n < 50) begin
      @(posedge CLK); #1;
      n++;
    end
    if (BUSY) check("idle_timeout", 1, 0);
  endtask

  task automatic issue(input logic [7:0] a, input logic [7:0] b, input logic [7:0] mm,
                       input logic [8:0] mu, input longint exp);
    wait_idle();
    @(posedge CLK); #1;
    A = a; B = b; M = mm; MU = mu; START = 1'b1;
    sb.push_back(exp);
    @(posedge CLK); #1;
    START = 1'b0;
  endtask

  typedef struct { logic [7:0] a, b, mm; longint exp; } vec_t;
  vec_t vecs[$];

  initial begin
    vec_t v;
    longint rexp;
    int n;

    // Reset state
    #2;
    check("rst_dp_rst", DP_RST, 0);
    check("rst_busy", BUSY, 0);
    check("rst_valid", RES_VALID, 0);
    check("rst_result", RESULT, 0);
    check("rst_y", DP_Y_I, 0);
    check("rst_x", DP_X, 0);
    check("carry_add", DP_CARRY_ADD, 0);
    check("carry_sub", DP_CARRY_SUB, 1);
    @(negedge CLK); RST = 1'b1;
    @(posedge CLK); #1;
    check("first_edge_dp_rst", DP_RST, 1);

    // Single op: 200*150 mod 251 = 131, digit stream 0,9,6
    @(posedge CLK); #1;
    A = 8'd200; B = 8'd150; M = 8'd251; MU = 9'd261; START = 1'b1;
    sb.push_back(131);
    @(posedge CLK); #1;
    START = 1'b0;
    A = 8'd7; B = 8'd7; M = 8'd7;
    check("clr_dp_rst", DP_RST, 0);
    check("clr_busy", BUSY, 1);
    check("latched_x", DP_X, 200);
    check("latched_m", DP_M, 251);
    check("latched_mu", DP_MU, 261);
    @(posedge CLK); #1;
    check("zero_dp_rst", DP_RST, 1);
    check("digit0", DP_Y_I, 0);
    @(posedge CLK); #1;
    check("digit1", DP_Y_I, 9);
    @(posedge CLK); #1;
    check("digit2", DP_Y_I, 6);
    check("carry_sub_op", DP_CARRY_SUB, 1);

    // Directed vectors incl. edge operands
    vecs.push_back('{8'd0,   8'd77,  8'd13,  0});
    vecs.push_back('{8'd255, 8'd255, 8'd255, 0});
    vecs.push_back('{8'd123, 8'd45,  8'd1,   0});
    vecs.push_back('{8'd17,  8'd3,   8'd100, 51});
    vecs.push_back('{8'd12,  8'd11,  8'd97,  35});
    vecs.push_back('{8'd250, 8'd250, 8'd251, 1});
    vecs.push_back('{8'd16,  8'd16,  8'd200, 56});
    foreach (vecs[i]) begin
      v = vecs[i];
      issue(v.a, v.b, v.mm, 9'd17, v.exp);
    end

    // Final-reduce path: Z_OUT forced to M+3
    wait_idle();
    zforce = 1'b1;
`ifdef BARRETT_SEQ_FINAL_REDUCE_EN
    rexp = 3;
`else
    rexp = 103;
`endif
    issue(8'd5, 8'd5, 8'd100, 9'd0, rexp);
    wait_idle();
    zforce = 1'b0;

    // Back-pressure: hold result for 10 cycles, START pulses ignored
    RES_READY = 1'b0;
    issue(8'd30, 8'd40, 8'd101, 9'd5, 89);
    n = 0;
    while (!RES_VALID && n < 20) begin
      @(posedge CLK); #1;
      n++;
    end
    check("bp_valid_seen", RES_VALID, 1);
    for (int k = 0; k < 10; k++) begin
      @(posedge CLK); #1;
      START = (k == 3 || k == 6);
      A = 8'd99; M = 8'd99;
      check("bp_hold_valid", RES_VALID, 1);
      check("bp_hold_result", RESULT, 89);
      check("bp_busy", BUSY, 1);
      check("bp_x_stable", DP_X, 30);
    end
    START = 1'b1;
    RES_READY = 1'b1;
    @(posedge CLK); #1;
    START = 1'b0;
    check("bp_release_idle", BUSY, 0);
    @(posedge CLK); #1;
    check("bp_start_ignored", BUSY, 0);

    // Reset mid-DIG: abort, no RES_VALID afterwards
    @(posedge CLK); #1;
    A = 8'd9; B = 8'd9; M = 8'd50; START = 1'b1;
    @(posedge CLK); #1;
    START = 1'b0;
    @(posedge CLK); @(posedge CLK); #2;
    RST = 1'b0;
    #1;
    check("abort_busy", BUSY, 0);
    check("abort_dp_rst", DP_RST, 0);
    check("abort_y", DP_Y_I, 0);
    check("abort_x", DP_X, 0);
    check("abort_result", RESULT, 0);
    @(negedge CLK); RST = 1'b1;
    n = 0;
    for (int k = 0; k < 12; k++) begin
      @(posedge CLK); #1;
      if (RES_VALID) n++;
    end
    check("abort_no_valid", n, 0);
    check("abort_idle", BUSY, 0);

    // Recovery op after abort
    issue(8'd100, 8'd3, 8'd7, 9'd1, 6);
    wait_idle();
    @(posedge CLK); #1;
    check("scoreboard_empty", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
